// File: rtl/sram_arbiter.sv
// N_REQ-way arbiter sharing one single-port synchronous sram: round-robin grant, registered command stage, tagged read return.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotation pointer).
module sram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 6,
    parameter int N_REQ      = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_wdata,
    output logic [N_REQ-1:0]            o_ack,
    output logic [N_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic                        o_mem_write,
    output logic [DATA_WIDTH-1:0]       o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]       i_mem_rdata
);
    localparam int IDW    = $clog2(N_REQ);
    localparam int STAGES = 2;

    // Packed views share the flat bus layout, so lane k is slice k directly.
    logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_lane;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] wdata_lane;
    assign addr_lane  = i_addr;
    assign wdata_lane = i_wdata;

    logic [N_REQ-1:0]            grant;
    logic [IDW-1:0]              win;
    logic                        accept;
    logic [STAGES-1:0]           vld_pipe;
    logic [STAGES-1:0][IDW-1:0]  id_pipe;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant  = '0;
        win    = '0;
        accept = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                win    = IDW'(i);
                accept = 1'b1;
            end
        end
        if (!i_rst_n) accept = 1'b0;
        if (accept) grant[win] = 1'b1;
    end
`else
    logic [IDW-1:0] last;
    logic [IDW-1:0] idx;

    // Search starts one past the last winner and wraps once around.
    always_comb begin
        grant  = '0;
        win    = '0;
        idx    = '0;
        accept = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IDW'((int'(last) + i) % N_REQ);
            if (!accept && i_req[idx]) begin
                win    = idx;
                accept = 1'b1;
            end
        end
        if (!i_rst_n) accept = 1'b0;
        if (accept) grant[win] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    last <= IDW'(N_REQ - 1);
        else if (accept) last <= win;
    end
`endif

    assign o_ack = grant;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_write <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
            o_rvalid    <= '0;
            o_rdata     <= '0;
        end else begin
            // Idle cycles leave addr/wdata in place; the sram just re-reads.
            o_mem_write <= accept & i_we[win];
            if (accept) begin
                o_mem_addr  <= addr_lane[win];
                o_mem_wdata <= wdata_lane[win];
            end
            vld_pipe <= {vld_pipe[0], accept & ~i_we[win]};
            id_pipe  <= {id_pipe[0], win};
            o_rvalid <= vld_pipe[STAGES-1] ? (N_REQ'(1) << id_pipe[STAGES-1]) : '0;
            if (vld_pipe[STAGES-1]) o_rdata <= i_mem_rdata;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: vector table with expected grants, sram model, and a scoreboard of read returns.
module tb_sram_arbiter;
    localparam int AW = 8;
    localparam int DW = 6;
    localparam int N  = 2;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    ack;
    } vec_t;

    typedef struct {
        logic [1:0]    rv;
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, we, ack, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_write;
    logic            preload;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] exp_mem [256];
    sb_t           q[$];
    vec_t          tbl[$];
    sb_t           e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            rv_run = 0;
    int            rv_max = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .o_ack(ack), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Single-port sram: registered read, write-xor-read each edge; preload fills mem[a] = a.
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
        else if (mem_write) mem[mem_addr] <= mem_wdata;
        else mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid != '0) begin
            rv_run++;
            if (rv_run > rv_max) rv_max = rv_run;
        end else begin
            rv_run = 0;
        end
        if (rst_n === 1'b1 && rvalid != '0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got %b, expected none", rvalid);
            end else begin
                e = q.pop_front();
                chk("rvalid", 32'(rvalid), 32'(e.rv));
                chk("rdata", 32'(rdata), 32'(e.data));
                chk("read_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Drive one cycle; the expected grant decides what the scoreboard records.
    task automatic drive(input vec_t v, input bit track);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req   = v.req;
        we    = v.we;
        addr  = {v.a1, v.a0};
        wdata = {v.d1, v.d0};
        @(negedge clk);
        chk("ack", 32'(ack), 32'(v.ack));
        if (track) begin
            for (int k = 0; k < N; k++) begin
                if (v.ack[k] && v.req[k]) begin
                    a = (k == 0) ? v.a0 : v.a1;
                    d = (k == 0) ? v.d0 : v.d1;
                    if (v.we[k]) exp_mem[a] = d;
                    else q.push_back('{rv: 2'(1 << k), data: exp_mem[a], due: cyc + 3});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1, input logic [1:0] k);
        vec_t v;
        v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.ack = k;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        idle    = mk(2'b00, 2'b00, 8'h00, 8'h00, 6'h00, 6'h00, 2'b00);
        rst_n   = 1'b0;
        preload = 1'b1;
        req     = 2'b11;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        for (int i = 0; i < 256; i++) exp_mem[i] = DW'(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(ack), 0);
        chk("reset_mem_write", 32'(mem_write), 0);
        chk("reset_rvalid", 32'(rvalid), 0);
        chk("reset_rdata", 32'(rdata), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        preload = 1'b0;
        req     = '0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // Contention from reset: requester 0 wins first, then alternation.
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'b11, 2'b00, 8'h20, 8'h21, 6'h00, 6'h00,
                             (FIXED || i % 2 == 0) ? 2'b01 : 2'b10));
        tbl.push_back(idle);
        // Write then read of the same address on consecutive cycles.
        tbl.push_back(mk(2'b01, 2'b01, 8'h12, 8'h00, 6'h2A, 6'h00, 2'b01));
        tbl.push_back(mk(2'b01, 2'b00, 8'h12, 8'h00, 6'h00, 6'h00, 2'b01));
        tbl.push_back(idle);
        // Top address: written by one requester, read back by the other.
        tbl.push_back(mk(2'b10, 2'b10, 8'h00, 8'hFF, 6'h00, 6'h01, 2'b10));
        tbl.push_back(mk(2'b01, 2'b00, 8'hFF, 8'h00, 6'h00, 6'h00, 2'b01));
        tbl.push_back(idle);
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(2'b10, 2'b00, 8'h00, 8'(i), 6'h00, 6'h00, 2'b10));
        for (int i = 0; i < 4; i++) tbl.push_back(idle);

        foreach (tbl[i]) drive(tbl[i], 1'b1);
        chk("drain_after_table", 32'(q.size()), 0);
        chk("b2b_rvalid_run", 32'(rv_max), 8);

        // Reset right after a read of 0x05 and a write to 0x05 are acked.
        drive(mk(2'b10, 2'b00, 8'h00, 8'h05, 6'h00, 6'h00, 2'b10), 1'b0);
        drive(mk(2'b01, 2'b01, 8'h05, 8'h00, 6'h2C, 6'h00, 2'b01), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_cancels_write", 32'(mem_write), 0);
        chk("reset_ack_gated", 32'(ack), 0);
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) drive(idle, 1'b1);
        chk("no_rvalid_after_reset", 32'(rvalid), 0);
        drive(mk(2'b01, 2'b00, 8'h05, 8'h00, 6'h00, 6'h00, 2'b01), 1'b1);
        repeat (4) drive(idle, 1'b1);
        chk("drain_final", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
